// File: rtl/div_iter_unit.sv
// Multi-cycle radix-2 restoring divider producing {remainder, quotient} for MIPS DIV/DIVU.
// Optional build macro DIV_EARLY_OUT_EN: skip iteration when |a| < |b| (b != 0).
module div_iter_unit #(
  parameter int WIDTH = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_signed_div,
  input  logic               i_cancel,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_hilo_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_div;
  logic               r_neg_a;
  logic               r_neg_q;
  logic               r_div_zero;
  logic [2*WIDTH-1:0] r_hilo;

  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic               w_early;
  logic               w_accept;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_quo_next;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_neg_a  = i_signed_div & i_a[WIDTH-1];
  assign w_neg_b  = i_signed_div & i_b[WIDTH-1];
  assign w_abs_a  = w_neg_a ? -i_a : i_a;
  assign w_abs_b  = w_neg_b ? -i_b : i_b;
  assign w_accept = i_start & ~i_cancel;

`ifdef DIV_EARLY_OUT_EN
  assign w_early = (i_b != '0) && (w_abs_a < w_abs_b);
`else
  assign w_early = 1'b0;
`endif

  // Remainder compare runs one bit wider than the operands so the shifted-in MSB is never lost.
  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_ge       = (w_shift >= {1'b0, r_div});
  assign w_diff     = w_shift[WIDTH-1:0] - r_div;
  assign w_rem_next = w_ge ? w_diff : w_shift[WIDTH-1:0];
  assign w_quo_next = {r_quo[WIDTH-2:0], w_ge};

  // A zero divisor leaves the magnitude of a in the remainder, so only the quotient needs forcing.
  assign w_quo_fix = r_div_zero ? '1 : (r_neg_q ? -r_quo : r_quo);
  assign w_rem_fix = r_neg_a ? -r_rem : r_rem;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    o_busy       = (r_state != S_IDLE);
    o_done       = (r_state == S_DONE);
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = w_early ? S_FIX : S_CALC;
      end
      S_CALC: begin
        if (i_cancel)                w_state_next = S_IDLE;
        else if (r_cnt == LAST_CNT)  w_state_next = S_FIX;
      end
      S_FIX: begin
        w_state_next = i_cancel ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_div      <= '0;
      r_neg_a    <= 1'b0;
      r_neg_q    <= 1'b0;
      r_div_zero <= 1'b0;
      r_hilo     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt      <= '0;
            r_neg_a    <= w_neg_a;
            r_neg_q    <= w_neg_a ^ w_neg_b;
            r_div_zero <= (i_b == '0);
            r_div      <= w_abs_b;
            if (w_early) begin
              r_rem <= w_abs_a;
              r_quo <= '0;
            end else begin
              r_rem <= '0;
              r_quo <= w_abs_a;
            end
          end
        end
        S_CALC: begin
          if (!i_cancel) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_FIX: begin
          if (!i_cancel) r_hilo <= {w_rem_fix, w_quo_fix};
        end
        default: ;
      endcase
    end
  end

  assign o_hilo_out = r_hilo;

endmodule

// File: tb/tb_div_iter_unit.sv
// Directed self-checking bench for div_iter_unit: latency, signed/unsigned results,
// divide-by-zero, overflow, cancel, reset and ignored starts.
module tb_div_iter_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signedDiv;
  logic        cancel;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] hiloOut;

  int nAsserts = 0;
  int nFail    = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam int SmallLat = 2;
`else
  localparam int SmallLat = 34;
`endif

  div_iter_unit #(.WIDTH(32)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_signed_div (signedDiv),
    .i_cancel     (cancel),
    .i_a          (a),
    .i_b          (b),
    .o_busy       (busy),
    .o_done       (done),
    .o_hilo_out   (hiloOut)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one operation, optionally re-pulsing start mid-flight, and checks latency, result and return to idle.
  task automatic applyStimulus(input string tag, input logic sd, input logic [31:0] va,
                               input logic [31:0] vb, input int expLat,
                               input logic [63:0] expHilo, input int intrudeCycle);
    int lat;
    signedDiv = sd;
    a         = va;
    b         = vb;
    start     = 1'b1;
    tick();
    lat = 1;
    checkOutput({tag, "_busy1"}, {63'd0, busy}, 64'd1);
    while (done !== 1'b1 && lat < 60) begin
      if (lat == intrudeCycle) begin
        start = 1'b1; signedDiv = 1'b1; a = 32'd9; b = 32'd3;
      end else begin
        start = 1'b0; a = $urandom; b = $urandom;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    checkOutput({tag, "_lat"}, 64'(lat), 64'(expLat));
    checkOutput({tag, "_hilo"}, hiloOut, expHilo);
    checkOutput({tag, "_busyDone"}, {63'd0, busy}, 64'd1);
    tick();
    checkOutput({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    bit sawDone;
    rst = 1'b1; start = 1'b0; signedDiv = 1'b0; cancel = 1'b0; a = '0; b = '0;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("reset_done", {63'd0, done}, 64'd0);
    checkOutput("reset_hilo", hiloOut, 64'd0);

    start = 1'b1; cancel = 1'b1; a = 32'd100; b = 32'd7;
    tick();
    start = 1'b0; cancel = 1'b0;
    checkOutput("startCancelIdle", {62'd0, busy, done}, 64'd0);

    applyStimulus("divu100_7", 1'b0, 32'd100, 32'd7, 34, 64'h00000002_0000000E, 0);
    applyStimulus("divNeg7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 34, 64'hFFFFFFFF_FFFFFFFD, 0);
    applyStimulus("div7_neg2", 1'b1, 32'd7, 32'hFFFFFFFE, 34, 64'h00000001_FFFFFFFD, 0);
    applyStimulus("divOvf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 34, 64'h00000000_80000000, 0);
    applyStimulus("divu5_0", 1'b0, 32'd5, 32'd0, 34, 64'h00000005_FFFFFFFF, 0);
    applyStimulus("divNeg5_0", 1'b1, 32'hFFFFFFFB, 32'd0, 34, 64'hFFFFFFFB_FFFFFFFF, 0);
    applyStimulus("divu3_10", 1'b0, 32'd3, 32'd10, SmallLat, 64'h00000003_00000000, 0);
    applyStimulus("divuMax_16", 1'b0, 32'hFFFFFFFF, 32'd16, 34, 64'h0000000F_0FFFFFFF, 0);

    // Cancel mid-CALC: result register must keep the divuMax_16 value
    signedDiv = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 2; i <= 10; i++) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    checkOutput("cancel_busy", {63'd0, busy}, 64'd0);
    sawDone = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) sawDone = 1'b1;
      tick();
    end
    checkOutput("cancel_noDone", {63'd0, sawDone}, 64'd0);
    checkOutput("cancel_hilo", hiloOut, 64'h0000000F_0FFFFFFF);

    applyStimulus("ignoredStart", 1'b0, 32'd100, 32'd7, 34, 64'h00000002_0000000E, 5);

    // Reset in the middle of an operation
    signedDiv = 1'b1; a = 32'd1000; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 2; i <= 15; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midReset_flags", {62'd0, busy, done}, 64'd0);
    checkOutput("midReset_hilo", hiloOut, 64'd0);

    applyStimulus("b2bFirst", 1'b1, 32'd1000, 32'd3, 34, 64'h00000001_0000014D, 0);
    applyStimulus("b2bSecond", 1'b0, 32'd12345, 32'd100, 34, 64'h0000002D_0000007B, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
